// File: rtl/fifo_burst_pkg.sv
// Shared types for the FIFO burst reader.
package fifo_burst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } state_t;

  // Beats that may be outstanding at once (output buffer slots).
  localparam int unsigned OBUF_DEPTH = 2;

endpackage

// File: rtl/fifo_burst_obuf.sv
// Two-entry valid/ready output buffer for the burst reader.
module fifo_burst_obuf #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [1:0]        cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t      slot_q [2];
  beat_t      slot_d [2];
  logic       wptr_q, wptr_d;
  logic       rptr_q, rptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       pop;

  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = slot_q[rptr_q].data;
  assign out_last  = slot_q[rptr_q].last;
  assign cnt       = cnt_q;

  // On a full buffer with push and pop together, wptr equals rptr: the head
  // is read combinationally this cycle and overwritten at the edge.
  always_comb begin
    slot_d = slot_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      slot_d[wptr_q] = '{data: push_data, last: push_last};
      wptr_d         = ~wptr_q;
    end
    if (pop) begin
      rptr_d = ~rptr_q;
    end
    cnt_d = cnt_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '{default: '0};
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      slot_q <= slot_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst master: drains an async FIFO in bursts onto a valid/ready stream.
module fifo_burst_reader
  import fifo_burst_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned AW        = 5,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  output logic              rd,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_data_vld,
  input  logic              empty,
  input  logic [AW:0]       rd_num,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              err_unexp,
  output logic [15:0]       beat_cnt
);

  localparam int unsigned TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW:0] BURST_N    = (AW + 1)'(BURST_LEN);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [AW:0]   rd_left_q, rd_left_d;
  logic [AW:0]   push_left_q, push_left_d;
  logic          inflight_q, inflight_d;
  logic          err_q, err_d;
  logic [15:0]   beat_cnt_q, beat_cnt_d;

  logic [1:0]    obuf_cnt;
  logic          pop;
  logic          push;
  logic          push_last;
  logic [2:0]    occ;

  assign pop       = out_valid & out_ready;
  assign push      = rd_data_vld & inflight_q;
  assign push_last = (push_left_q == (AW + 1)'(1));
  assign occ       = 3'(obuf_cnt) + 3'(inflight_q) - 3'(pop);

  assign busy      = (state_q != IDLE);
  assign err_unexp = err_q;
  assign beat_cnt  = beat_cnt_q;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    rd_left_d   = rd_left_q;
    push_left_d = push_left_q;
    rd          = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (rd_num >= BURST_N) begin
          state_d     = DRAIN;
          rd_left_d   = BURST_N;
          push_left_d = BURST_N;
        end else if (rd_num != '0) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (rd_num >= BURST_N) begin
          state_d     = DRAIN;
          rd_left_d   = BURST_N;
          push_left_d = BURST_N;
        end else if (rd_num == '0) begin
          state_d = IDLE;
        end else if (timer_q == TIMER_LAST) begin
          state_d     = DRAIN;
          rd_left_d   = rd_num;
          push_left_d = rd_num;
        end
      end
      DRAIN: begin
        rd = (rd_left_q != '0) && !empty && (occ < 3'(OBUF_DEPTH));
        if (rd) begin
          rd_left_d = rd_left_q - 1'b1;
        end
        if (push) begin
          push_left_d = push_left_q - 1'b1;
        end
        if (pop && out_last) begin
          state_d = IDLE;
          timer_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    inflight_d = rd | (inflight_q & ~rd_data_vld);
    err_d      = err_q | (rd_data_vld & ~inflight_q);
    beat_cnt_d = beat_cnt_q + 16'(pop);
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      rd_left_q   <= '0;
      push_left_q <= '0;
      inflight_q  <= 1'b0;
      err_q       <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      rd_left_q   <= rd_left_d;
      push_left_q <= push_left_d;
      inflight_q  <= inflight_d;
      err_q       <= err_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  fifo_burst_obuf #(
    .DATA_W(DATA_W)
  ) u_obuf (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .push      (push),
    .push_data (rd_data),
    .push_last (push_last),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .cnt       (obuf_cnt)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

  logic        rd_clk = 1'b0;
  logic        rd_rst;
  logic        rd;
  logic [7:0]  rd_data;
  logic        rd_data_vld;
  logic        empty;
  logic [5:0]  rd_num;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic        busy;
  logic        err_unexp;
  logic [15:0] beat_cnt;

  int vectors = 0;
  int miscompares = 0;

  bit [7:0] fifo_q [$];
  bit [7:0] wr_q [$];
  bit [8:0] exp_q [$];

  int   tick_n, rd_count, pop_count, lasts_seen, held, total_beats;
  int   first_rd_tick, last_rd_tick, first_pop_tick, last_pop_tick, first_vis_tick;
  int   ready_mode;
  bit   inject_vld, prev_stall;
  logic [7:0] prev_data;
  logic       prev_last;

  always #25 rd_clk = ~rd_clk;

  fifo_burst_reader #(
    .DATA_W(8),
    .AW(5),
    .BURST_LEN(8),
    .TIMEOUT(64)
  ) dut (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .rd          (rd),
    .rd_data     (rd_data),
    .rd_data_vld (rd_data_vld),
    .empty       (empty),
    .rd_num      (rd_num),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .busy        (busy),
    .err_unexp   (err_unexp),
    .beat_cnt    (beat_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_scen();
    rd_count = 0; pop_count = 0; lasts_seen = 0;
    first_rd_tick = -1; last_rd_tick = -1;
    first_pop_tick = -1; last_pop_tick = -1; first_vis_tick = -1;
  endtask

  // One write session: split into bursts of `burst` with the remainder as a partial burst.
  task automatic queue_bytes(input bit [7:0] d [$], input int burst);
    for (int i = 0; i < d.size(); i++) begin
      bit last;
      last = ((i % burst) == burst - 1) || (i == d.size() - 1);
      wr_q.push_back(d[i]);
      exp_q.push_back({last, d[i]});
    end
  endtask

  // Sample at negedge, then model the FIFO read side just after posedge.
  task automatic tick();
    bit rd_s, pop;
    bit [8:0] e;
    @(negedge rd_clk);
    tick_n++;
    rd_s = (rd === 1'b1);
    pop  = (out_valid === 1'b1) && (out_ready === 1'b1);
    if (prev_stall) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'(prev_data));
      check("hold_last", 32'(out_last), 32'(prev_last));
    end
    if (rd_s) begin
      rd_count++;
      if (first_rd_tick < 0) first_rd_tick = tick_n;
      last_rd_tick = tick_n;
      check("rd_vs_empty", 32'(empty), 32'd0);
      check("rd_credit", 32'((held - int'(pop)) < 2), 32'd1);
    end
    if (pop) begin
      check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat_data", 32'(out_data), 32'(e[7:0]));
        check("beat_last", 32'(out_last), 32'(e[8]));
        if (e[8]) lasts_seen++;
      end
      total_beats++;
      pop_count++;
      held--;
      if (first_pop_tick < 0) first_pop_tick = tick_n;
      last_pop_tick = tick_n;
    end
    if (rd_s) held++;
    prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
    prev_data  = out_data;
    prev_last  = out_last;

    @(posedge rd_clk);
    #1;
    rd_data_vld = 1'b0;
    if (rd_s && fifo_q.size() != 0) begin
      rd_data     = fifo_q.pop_front();
      rd_data_vld = 1'b1;
    end
    if (inject_vld) begin
      rd_data     = 8'hEE;
      rd_data_vld = 1'b1;
      inject_vld  = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (wr_q.size() != 0) begin
        if (fifo_q.size() == 0 && first_vis_tick < 0) first_vis_tick = tick_n + 1;
        fifo_q.push_back(wr_q.pop_front());
      end
    end
    rd_num = 6'(fifo_q.size());
    empty  = (fifo_q.size() == 0);
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      2:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic drain(input string tag, input int limit);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || wr_q.size() != 0 || busy !== 1'b0) && k < limit) begin
      tick();
      k++;
    end
    check({tag, "_drained"}, 32'(k < limit), 32'd1);
  endtask

  initial begin
    bit [7:0] d [$];
    int k;
    rd_rst = 1'b1; rd_data_vld = 1'b0; rd_data = '0; empty = 1'b1; rd_num = '0;
    out_ready = 1'b1; inject_vld = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    held = 0; total_beats = 0; ready_mode = 0; tick_n = 0;
    new_scen();

    @(negedge rd_clk);
    check("rst_rd", 32'(rd), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_unexp), 32'd0);
    check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    @(posedge rd_clk);
    #1 rd_rst = 1'b0;
    repeat (2) tick();

    // Full burst 0x00..0x07 with ready held high
    new_scen();
    d.delete();
    for (int i = 0; i < 8; i++) d.push_back(8'(i));
    queue_bytes(d, 8);
    drain("s1", 100);
    check("s1_rd_count", 32'(rd_count), 32'd8);
    check("s1_rd_consec", 32'(last_rd_tick - first_rd_tick), 32'd7);
    check("s1_beats_consec", 32'(last_pop_tick - first_pop_tick), 32'd7);
    check("s1_latency", 32'(first_pop_tick - first_rd_tick), 32'd2);
    check("s1_lasts", 32'(lasts_seen), 32'd1);
    check("s1_beat_cnt", 32'(beat_cnt), 32'(total_beats));
    check("s1_idle", 32'(busy), 32'd0);

    // Partial burst after the idle timeout
    new_scen();
    d = {8'hA1, 8'hA2, 8'hA3};
    queue_bytes(d, 8);
    drain("s2", 200);
    check("s2_timeout", 32'(first_rd_tick - first_vis_tick), 32'd65);
    check("s2_rd_count", 32'(rd_count), 32'd3);
    check("s2_lasts", 32'(lasts_seen), 32'd1);
    check("s2_beat_cnt", 32'(beat_cnt), 32'(total_beats));

    // 32 random bytes, alternating then random ready
    new_scen();
    d.delete();
    for (int i = 0; i < 32; i++) d.push_back(8'($urandom));
    queue_bytes(d, 8);
    ready_mode = 2;
    repeat (8) tick();
    ready_mode = 3;
    drain("s3", 800);
    ready_mode = 0;
    out_ready = 1'b1;
    check("s3_bursts", 32'(lasts_seen), 32'd4);
    check("s3_rd_count", 32'(rd_count), 32'd32);
    check("s3_pops", 32'(pop_count), 32'd32);
    check("s3_beat_cnt", 32'(beat_cnt), 32'(total_beats));

    // Stall during a burst
    new_scen();
    ready_mode = 1;
    out_ready = 1'b0;
    d.delete();
    for (int i = 0; i < 8; i++) d.push_back(8'($urandom));
    queue_bytes(d, 8);
    repeat (30) tick();
    check("s4_rd_stalled", 32'(rd_count), 32'd2);
    check("s4_valid_stalled", 32'(out_valid), 32'd1);
    ready_mode = 0;
    out_ready = 1'b1;
    drain("s4", 100);
    check("s4_rd_count", 32'(rd_count), 32'd8);
    check("s4_pops", 32'(pop_count), 32'd8);
    check("s4_lasts", 32'(lasts_seen), 32'd1);

    // Unexpected read data
    new_scen();
    check("s5_err_before", 32'(err_unexp), 32'd0);
    inject_vld = 1'b1;
    repeat (2) tick();
    check("s5_err_set", 32'(err_unexp), 32'd1);
    check("s5_no_beat", 32'(out_valid), 32'd0);
    repeat (10) tick();
    check("s5_err_sticky", 32'(err_unexp), 32'd1);
    check("s5_idle", 32'(busy), 32'd0);
    check("s5_beat_cnt", 32'(beat_cnt), 32'(total_beats));

    // Reset after 4 beats of a burst
    new_scen();
    d.delete();
    for (int i = 0; i < 8; i++) d.push_back(8'($urandom));
    queue_bytes(d, 8);
    k = 0;
    while (pop_count < 4 && k < 100) begin
      tick();
      k++;
    end
    check("s6_four_beats", 32'(pop_count), 32'd4);
    #2 rd_rst = 1'b1;
    #1;
    check("s6_rst_rd", 32'(rd), 32'd0);
    check("s6_rst_out_valid", 32'(out_valid), 32'd0);
    check("s6_rst_out_last", 32'(out_last), 32'd0);
    check("s6_rst_out_data", 32'(out_data), 32'd0);
    check("s6_rst_busy", 32'(busy), 32'd0);
    check("s6_rst_err", 32'(err_unexp), 32'd0);
    check("s6_rst_beat_cnt", 32'(beat_cnt), 32'd0);
    fifo_q.delete(); wr_q.delete(); exp_q.delete();
    held = 0; total_beats = 0; prev_stall = 1'b0;
    rd_data_vld = 1'b0; rd_num = '0; empty = 1'b1;
    repeat (3) tick();
    rd_rst = 1'b0;
    repeat (2) tick();
    new_scen();
    d.delete();
    for (int i = 0; i < 8; i++) d.push_back(8'($urandom));
    queue_bytes(d, 8);
    drain("s6", 100);
    check("s6_rd_count", 32'(rd_count), 32'd8);
    check("s6_pops", 32'(pop_count), 32'd8);
    check("s6_beats_consec", 32'(last_pop_tick - first_pop_tick), 32'd7);
    check("s6_lasts", 32'(lasts_seen), 32'd1);
    check("s6_beat_cnt", 32'(beat_cnt), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
